// File: rtl/rob_mc.sv
// rtl/rob_mc.sv - reorder buffer with NUM_CDB completion channels and COMMIT_W-wide in-order retirement
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   disp_*               dispatch handshake and entry fields; disp_idx is the allocated index (tail)
//   cdb_*                per-channel completion strobe, ROB index, mispredict flag and correct target
//   commit_*             per-slot retirement (slot 0 oldest); data fields are zero for idle slots
//   flush, flush_pc      registered one-cycle pipeline flush and fetch redirect target
//   count                occupied entries
module rob_mc #(
    parameter int DEPTH    = 32,
    parameter int PREG_W   = 6,
    parameter int NUM_CDB  = 4,
    parameter int COMMIT_W = 2,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      disp_valid,
    output logic                      disp_ready,
    input  logic [PREG_W-1:0]         disp_pd,
    input  logic [4:0]                disp_rd,
    input  logic                      disp_we,
    input  logic [31:0]               disp_pc,
    output logic [IDX_W-1:0]          disp_idx,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*IDX_W-1:0]  cdb_idx,
    input  logic [NUM_CDB-1:0]        cdb_redirect,
    input  logic [NUM_CDB*32-1:0]     cdb_target,
    output logic [COMMIT_W-1:0]       commit_valid,
    output logic [COMMIT_W*PREG_W-1:0] commit_pd,
    output logic [COMMIT_W*5-1:0]     commit_rd,
    output logic [COMMIT_W-1:0]       commit_we,
    output logic [COMMIT_W*32-1:0]    commit_pc,
    output logic                      flush,
    output logic [31:0]               flush_pc,
    output logic [IDX_W:0]            count
);

    logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [IDX_W:0]    count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d, redir_q, redir_d, we_q, we_d;
    logic [31:0]       target_q [DEPTH];
    logic [31:0]       target_d [DEPTH];
    logic [31:0]       pc_q [DEPTH];
    logic [31:0]       pc_d [DEPTH];
    logic [PREG_W-1:0] pd_q [DEPTH];
    logic [PREG_W-1:0] pd_d [DEPTH];
    logic [4:0]        rd_q [DEPTH];
    logic [4:0]        rd_d [DEPTH];
    logic              flush_q, flush_d;
    logic [31:0]       flush_pc_q, flush_pc_d;

    logic [IDX_W-1:0]  slot_idx [COMMIT_W];
    logic [COMMIT_W-1:0] elig;
    logic              prev_ok;
    logic              flush_now;
    logic [31:0]       flush_tgt;
    logic [IDX_W:0]    ncommit;
    logic              disp_fire;
    logic [IDX_W-1:0]  cidx;

    // Commit selection looks only at registered state. A slot retires only if every
    // older slot retires and none of them is a mispredict, so at most one redirect
    // entry can retire per cycle and it is always the youngest retiring slot.
    always_comb begin
        prev_ok      = 1'b1;
        flush_now    = 1'b0;
        flush_tgt    = '0;
        ncommit      = '0;
        elig         = '0;
        commit_pd    = '0;
        commit_rd    = '0;
        commit_we    = '0;
        commit_pc    = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            slot_idx[k] = head_q + IDX_W'(k);
            elig[k]     = prev_ok & valid_q[slot_idx[k]] & done_q[slot_idx[k]];
            prev_ok     = elig[k] & ~redir_q[slot_idx[k]];
            ncommit     = ncommit + (IDX_W+1)'(elig[k]);
            if (elig[k]) begin
                commit_pd[k*PREG_W +: PREG_W] = pd_q[slot_idx[k]];
                commit_rd[k*5 +: 5]           = rd_q[slot_idx[k]];
                commit_we[k]                  = we_q[slot_idx[k]];
                commit_pc[k*32 +: 32]         = pc_q[slot_idx[k]];
                if (redir_q[slot_idx[k]]) begin
                    flush_now = 1'b1;
                    flush_tgt = target_q[slot_idx[k]];
                end
            end
        end
        commit_valid = elig;
    end

    assign disp_ready = (count_q != (IDX_W+1)'(DEPTH)) && !flush_now;
    assign disp_fire  = disp_valid && disp_ready;
    assign disp_idx   = tail_q;
    assign count      = count_q;
    assign flush      = flush_q;
    assign flush_pc   = flush_pc_q;

    always_comb begin
        valid_d  = valid_q;
        done_d   = done_q;
        redir_d  = redir_q;
        we_d     = we_q;
        target_d = target_q;
        pc_d     = pc_q;
        pd_d     = pd_q;
        rd_d     = rd_q;
        cidx     = '0;

        // Walk channels from highest to lowest so the lowest-numbered redirecting
        // channel is the last writer of target.
        if (!flush_now) begin
            for (int c = NUM_CDB-1; c >= 0; c--) begin
                cidx = cdb_idx[c*IDX_W +: IDX_W];
                if (cdb_valid[c] && valid_q[cidx]) begin
                    done_d[cidx] = 1'b1;
                    if (cdb_redirect[c]) begin
                        redir_d[cidx]  = 1'b1;
                        target_d[cidx] = cdb_target[c*32 +: 32];
                    end
                end
            end
        end

        for (int k = 0; k < COMMIT_W; k++) begin
            if (elig[k]) begin
                valid_d[slot_idx[k]] = 1'b0;
                done_d[slot_idx[k]]  = 1'b0;
                redir_d[slot_idx[k]] = 1'b0;
            end
        end

        if (disp_fire) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            redir_d[tail_q] = 1'b0;
            we_d[tail_q]    = disp_we;
            pc_d[tail_q]    = disp_pc;
            pd_d[tail_q]    = disp_pd;
            rd_d[tail_q]    = disp_rd;
        end

        head_d  = head_q + ncommit[IDX_W-1:0];
        tail_d  = tail_q + IDX_W'(disp_fire);
        count_d = count_q + (IDX_W+1)'(disp_fire) - ncommit;

        // Recovery at commit: everything younger than the mispredict is discarded.
        if (flush_now) begin
            valid_d = '0;
            done_d  = '0;
            redir_d = '0;
            tail_d  = head_d;
            count_d = '0;
        end

        flush_d    = flush_now;
        flush_pc_d = flush_now ? flush_tgt : flush_pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            done_q     <= '0;
            redir_q    <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            redir_q    <= redir_d;
            flush_q    <= flush_d;
            flush_pc_q <= flush_pc_d;
        end
    end

    // Payload fields are qualified by valid/done, so they need no reset.
    always_ff @(posedge clk) begin
        we_q     <= we_d;
        target_q <= target_d;
        pc_q     <= pc_d;
        pd_q     <= pd_d;
        rd_q     <= rd_d;
    end

endmodule

// File: tb/tb_rob_mc.sv
// tb/tb_rob_mc.sv - directed self-checking bench for rob_mc
module tb_rob_mc;

    localparam int DEPTH = 32;
    localparam int PREG_W = 6;
    localparam int NUM_CDB = 4;
    localparam int COMMIT_W = 2;
    localparam int IDX_W = 5;

    logic                        clk;
    logic                        rst;
    logic                        disp_valid;
    logic                        disp_ready;
    logic [PREG_W-1:0]           disp_pd;
    logic [4:0]                  disp_rd;
    logic                        disp_we;
    logic [31:0]                 disp_pc;
    logic [IDX_W-1:0]            disp_idx;
    logic [NUM_CDB-1:0]          cdb_valid;
    logic [NUM_CDB*IDX_W-1:0]    cdb_idx;
    logic [NUM_CDB-1:0]          cdb_redirect;
    logic [NUM_CDB*32-1:0]       cdb_target;
    logic [COMMIT_W-1:0]         commit_valid;
    logic [COMMIT_W*PREG_W-1:0]  commit_pd;
    logic [COMMIT_W*5-1:0]       commit_rd;
    logic [COMMIT_W-1:0]         commit_we;
    logic [COMMIT_W*32-1:0]      commit_pc;
    logic                        flush;
    logic [31:0]                 flush_pc;
    logic [IDX_W:0]              count;

    int n_chk;
    int n_err;

    rob_mc #(.DEPTH(DEPTH), .PREG_W(PREG_W), .NUM_CDB(NUM_CDB), .COMMIT_W(COMMIT_W)) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_pd(disp_pd),
        .disp_rd(disp_rd), .disp_we(disp_we), .disp_pc(disp_pc), .disp_idx(disp_idx),
        .cdb_valid(cdb_valid), .cdb_idx(cdb_idx), .cdb_redirect(cdb_redirect),
        .cdb_target(cdb_target),
        .commit_valid(commit_valid), .commit_pd(commit_pd), .commit_rd(commit_rd),
        .commit_we(commit_we), .commit_pc(commit_pc),
        .flush(flush), .flush_pc(flush_pc), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        disp_valid   = 1'b0;
        disp_pd      = '0;
        disp_rd      = '0;
        disp_we      = 1'b0;
        disp_pc      = '0;
        cdb_valid    = '0;
        cdb_idx      = '0;
        cdb_redirect = '0;
        cdb_target   = '0;
    endtask

    task automatic disp(input logic [31:0] pc, input int i);
        disp_valid = 1'b1;
        disp_pc    = pc;
        disp_pd    = 6'(i + 8);
        disp_rd    = 5'(i + 1);
        disp_we    = logic'(i & 1);
    endtask

    task automatic cdb(input int ch, input int idx, input logic red, input logic [31:0] tgt);
        cdb_valid[ch]            = 1'b1;
        cdb_idx[ch*IDX_W +: IDX_W] = 5'(idx);
        cdb_redirect[ch]         = red;
        cdb_target[ch*32 +: 32]  = tgt;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        clr();

        // Reset
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(disp_ready), 64'd1);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_cv", 64'(commit_valid), 64'd0);
        chk("rst_idx", 64'(disp_idx), 64'd0);

        // Fill to full with no completions
        for (int i = 0; i < 32; i++) begin
            disp(32'h100 + 32'(4*i), i);
            #1;
            chk("fill_idx", 64'(disp_idx), 64'(i));
            chk("fill_ready", 64'(disp_ready), 64'd1);
            tick();
        end
        #1;
        chk("full_ready", 64'(disp_ready), 64'd0);
        chk("full_count", 64'(count), 64'd32);
        clr();
        cdb(0, 0, 1'b0, 32'h0);
        #1;
        chk("full_cv_same_cycle", 64'(commit_valid), 64'd0);
        tick();
        clr();
        disp(32'hBAD0_0000, 0);
        #1;
        chk("full_commit_cv", 64'(commit_valid), 64'b01);
        chk("full_commit_pc", 64'(commit_pc), {32'h0, 32'h100});
        chk("full_commit_ready", 64'(disp_ready), 64'd0);
        tick();
        clr();
        #1;
        chk("reopen_count", 64'(count), 64'd31);
        chk("reopen_ready", 64'(disp_ready), 64'd1);
        chk("reopen_idx", 64'(disp_idx), 64'd0);

        // Reset mid-operation wins over dispatch and completion
        rst = 1'b1;
        disp(32'h0, 0);
        cdb(0, 1, 1'b1, 32'h1234);
        tick();
        rst = 1'b0;
        clr();
        #1;
        chk("rst2_count", 64'(count), 64'd0);
        chk("rst2_idx", 64'(disp_idx), 64'd0);
        chk("rst2_cv", 64'(commit_valid), 64'd0);
        chk("rst2_flush", 64'(flush), 64'd0);

        // Out-of-order completion, dual commit
        for (int i = 0; i < 4; i++) begin
            disp(32'h200 + 32'(4*i), i);
            tick();
        end
        clr();
        cdb(0, 3, 1'b0, 32'h0);
        cdb(1, 2, 1'b0, 32'h0);
        cdb(2, 1, 1'b0, 32'h0);
        #1;
        chk("ooo_cv_a", 64'(commit_valid), 64'd0);
        tick();
        clr();
        cdb(0, 0, 1'b0, 32'h0);
        #1;
        chk("ooo_cv_b", 64'(commit_valid), 64'b00);
        tick();
        clr();
        #1;
        chk("ooo_cv_c", 64'(commit_valid), 64'b11);
        chk("ooo_pc_c", 64'(commit_pc), {32'h204, 32'h200});
        chk("ooo_pd_c", 64'(commit_pd), 64'({6'd9, 6'd8}));
        chk("ooo_rd_c", 64'(commit_rd), 64'({5'd2, 5'd1}));
        chk("ooo_we_c", 64'(commit_we), 64'b10);
        chk("ooo_count_c", 64'(count), 64'd4);
        tick();
        #1;
        chk("ooo_cv_d", 64'(commit_valid), 64'b11);
        chk("ooo_pc_d", 64'(commit_pc), {32'h20C, 32'h208});
        chk("ooo_count_d", 64'(count), 64'd2);
        tick();
        #1;
        chk("ooo_count_e", 64'(count), 64'd0);
        chk("ooo_cv_e", 64'(commit_valid), 64'd0);

        // Redirect at commit
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clr();
        for (int i = 0; i < 6; i++) begin
            disp(32'h300 + 32'(4*i), i);
            tick();
        end
        clr();
        cdb(0, 0, 1'b0, 32'h0);
        cdb(1, 1, 1'b1, 32'h1000_0040);
        cdb(2, 2, 1'b0, 32'h0);
        cdb(3, 3, 1'b0, 32'h0);
        #1;
        chk("redir_cv_a", 64'(commit_valid), 64'd0);
        tick();
        clr();
        cdb(0, 4, 1'b0, 32'h0);
        cdb(1, 5, 1'b0, 32'h0);
        disp(32'hBAD0_0004, 9);
        #1;
        chk("redir_cv_b", 64'(commit_valid), 64'b11);
        chk("redir_pc_b", 64'(commit_pc), {32'h304, 32'h300});
        chk("redir_ready_b", 64'(disp_ready), 64'd0);
        chk("redir_flush_b", 64'(flush), 64'd0);
        tick();
        clr();
        #1;
        chk("redir_flush", 64'(flush), 64'd1);
        chk("redir_flush_pc", 64'(flush_pc), 64'h1000_0040);
        chk("redir_count", 64'(count), 64'd0);
        chk("redir_tail", 64'(disp_idx), 64'd2);
        chk("redir_ready", 64'(disp_ready), 64'd1);
        chk("redir_cv", 64'(commit_valid), 64'd0);
        cdb(0, 2, 1'b0, 32'h0);
        cdb(1, 3, 1'b0, 32'h0);
        cdb(2, 4, 1'b0, 32'h0);
        cdb(3, 5, 1'b0, 32'h0);
        tick();
        clr();
        #1;
        chk("redir_flush_drop", 64'(flush), 64'd0);
        chk("empty_cdb_cv", 64'(commit_valid), 64'd0);
        chk("empty_cdb_count", 64'(count), 64'd0);

        // Wrap-around: advance head to 31 then commit across the wrap
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clr();
        for (int i = 0; i < 31; i++) begin
            clr();
            disp(32'h500 + 32'(4*i), i);
            if (i > 0) cdb(0, i - 1, 1'b0, 32'h0);
            tick();
        end
        clr();
        cdb(0, 30, 1'b0, 32'h0);
        tick();
        clr();
        for (int w = 0; w < 8 && count != 0; w++) tick();
        chk("wrap_drain_count", 64'(count), 64'd0);
        chk("wrap_tail", 64'(disp_idx), 64'd31);
        disp(32'hA000, 3);
        #1;
        chk("wrap_idx_a", 64'(disp_idx), 64'd31);
        tick();
        disp(32'hA004, 4);
        #1;
        chk("wrap_idx_b", 64'(disp_idx), 64'd0);
        tick();
        clr();
        cdb(0, 31, 1'b0, 32'h0);
        cdb(1, 0, 1'b0, 32'h0);
        #1;
        chk("wrap_cv_a", 64'(commit_valid), 64'd0);
        tick();
        clr();
        #1;
        chk("wrap_cv", 64'(commit_valid), 64'b11);
        chk("wrap_pc", 64'(commit_pc), {32'hA004, 32'hA000});
        chk("wrap_count", 64'(count), 64'd2);
        tick();
        #1;
        chk("wrap_count_after", 64'(count), 64'd0);
        chk("wrap_head_tail", 64'(disp_idx), 64'd1);

        // Simultaneous CDB hits on one index, plus a hit on an invalid index
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clr();
        for (int i = 0; i < 5; i++) begin
            disp(32'h600 + 32'(4*i), i);
            tick();
        end
        clr();
        cdb(0, 4, 1'b0, 32'hDEAD_BEEF);
        cdb(1, 7, 1'b1, 32'h7777_0000);
        cdb(2, 4, 1'b1, 32'h2000_0080);
        tick();
        clr();
        cdb(0, 0, 1'b0, 32'h0);
        cdb(1, 1, 1'b0, 32'h0);
        cdb(2, 2, 1'b0, 32'h0);
        cdb(3, 3, 1'b0, 32'h0);
        #1;
        chk("conf_cv_a", 64'(commit_valid), 64'd0);
        tick();
        clr();
        #1;
        chk("conf_cv_b", 64'(commit_valid), 64'b11);
        tick();
        #1;
        chk("conf_cv_c", 64'(commit_valid), 64'b11);
        chk("conf_flush_c", 64'(flush), 64'd0);
        tick();
        #1;
        chk("conf_cv_d", 64'(commit_valid), 64'b01);
        chk("conf_pc_d", 64'(commit_pc), {32'h0, 32'h610});
        chk("conf_ready_d", 64'(disp_ready), 64'd0);
        chk("conf_count_d", 64'(count), 64'd1);
        tick();
        #1;
        chk("conf_flush", 64'(flush), 64'd1);
        chk("conf_flush_pc", 64'(flush_pc), 64'h2000_0080);
        chk("conf_count", 64'(count), 64'd0);
        chk("conf_tail", 64'(disp_idx), 64'd5);
        chk("conf_cv_e", 64'(commit_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
